// File: rtl/ascon_permutation_iter.sv
// Iterative Ascon permutation (1..12 rounds), UNROLL rounds per clock; latency ceil(n/UNROLL) edges, valid_o registered.
// Backpressure: none; start_i is honoured only while ready_o. Optional abort via ASCON_PERM_ABORT_EN.
// Results are held in state_o until the next accepted start.
module ascon_permutation_iter #(
    parameter int UNROLL = 1
) (
    input  logic         clock_i,
    input  logic         resetb_i,
    input  logic         start_i,
    input  logic [3:0]   rounds_i,
    input  logic [319:0] state_i,
`ifdef ASCON_PERM_ABORT_EN
    input  logic         abort_i,
`endif
    output logic         ready_o,
    output logic         valid_o,
    output logic [319:0] state_o
);

    if (UNROLL < 1 || UNROLL > 4) begin : g_bad_unroll
        $error("ascon_permutation_iter: UNROLL must be in 1..4");
    end

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } fsm_t;

    fsm_t         fsm_q;
    fsm_t         fsm_d;
    logic [3:0]   rnd_q;
    logic [3:0]   rnd_d;
    logic         valid_d;
    logic [319:0] state_d;

    logic [3:0]   n_eff;
    logic [3:0]   r_start;
    logic [3:0]   r_base;
    logic [4:0]   r_end;
    logic         last_group;
    logic [319:0] perm_in;
    logic [319:0] perm_out;
    logic [319:0] chain_acc;
    logic [4:0]   chain_idx;
    logic         abort;

`ifdef ASCON_PERM_ABORT_EN
    assign abort = abort_i;
`else
    assign abort = 1'b0;
`endif

    function automatic logic [63:0] ror64(input logic [63:0] x, input int unsigned n);
        ror64 = (x >> n) | (x << (64 - n));
    endfunction

    // One round: constant addition, bit-sliced S-box, linear diffusion.
    function automatic logic [319:0] ascon_round(input logic [319:0] s, input logic [3:0] r);
        logic [63:0] x0, x1, x2, x3, x4;
        logic [63:0] t0, t1, t2, t3, t4;
        {x0, x1, x2, x3, x4} = s;
        x2[7:0] = x2[7:0] ^ {4'hF - r, r};

        x0 = x0 ^ x4;
        x4 = x4 ^ x3;
        x2 = x2 ^ x1;
        t0 = ~x0 & x1;
        t1 = ~x1 & x2;
        t2 = ~x2 & x3;
        t3 = ~x3 & x4;
        t4 = ~x4 & x0;
        x0 = x0 ^ t1;
        x1 = x1 ^ t2;
        x2 = x2 ^ t3;
        x3 = x3 ^ t4;
        x4 = x4 ^ t0;
        x1 = x1 ^ x0;
        x0 = x0 ^ x4;
        x3 = x3 ^ x2;
        x2 = ~x2;

        x0 = x0 ^ ror64(x0, 19) ^ ror64(x0, 28);
        x1 = x1 ^ ror64(x1, 61) ^ ror64(x1, 39);
        x2 = x2 ^ ror64(x2, 1)  ^ ror64(x2, 6);
        x3 = x3 ^ ror64(x3, 10) ^ ror64(x3, 17);
        x4 = x4 ^ ror64(x4, 7)  ^ ror64(x4, 41);
        return {x0, x1, x2, x3, x4};
    endfunction

    assign n_eff      = (rounds_i == 4'd0 || rounds_i > 4'd12) ? 4'd12 : rounds_i;
    assign r_start    = 4'd12 - n_eff;
    assign r_base     = (fsm_q == IDLE) ? r_start : rnd_q;
    assign perm_in    = (fsm_q == IDLE) ? state_i : state_o;
    assign r_end      = {1'b0, r_base} + 5'(UNROLL);
    assign last_group = (r_end >= 5'd12);

    // Stages past round 11 pass through, so a short final group needs no special case.
    always_comb begin
        chain_acc = perm_in;
        chain_idx = 5'd0;
        for (int k = 0; k < UNROLL; k++) begin
            chain_idx = {1'b0, r_base} + 5'(k);
            if (chain_idx < 5'd12) begin
                chain_acc = ascon_round(chain_acc, chain_idx[3:0]);
            end
        end
        perm_out = chain_acc;
    end

    always_comb begin
        fsm_d   = fsm_q;
        rnd_d   = rnd_q;
        state_d = state_o;
        valid_d = 1'b0;
        case (fsm_q)
            IDLE: begin
                if (start_i) begin
                    state_d = perm_out;
                    rnd_d   = last_group ? 4'd12 : r_end[3:0];
                    if (last_group) begin
                        valid_d = 1'b1;
                    end else begin
                        fsm_d = BUSY;
                    end
                end
            end
            BUSY: begin
                if (abort) begin
                    fsm_d = IDLE;
                    rnd_d = 4'd0;
                end else begin
                    state_d = perm_out;
                    rnd_d   = last_group ? 4'd12 : r_end[3:0];
                    if (last_group) begin
                        valid_d = 1'b1;
                        fsm_d   = IDLE;
                    end
                end
            end
            default: fsm_d = IDLE;
        endcase
    end

    always_ff @(posedge clock_i or negedge resetb_i) begin
        if (!resetb_i) begin
            fsm_q   <= IDLE;
            rnd_q   <= 4'd0;
            valid_o <= 1'b0;
            state_o <= '0;
        end else begin
            fsm_q   <= fsm_d;
            rnd_q   <= rnd_d;
            valid_o <= valid_d;
            state_o <= state_d;
        end
    end

    assign ready_o = (fsm_q == IDLE);

endmodule

// File: doc/ascon_permutation_iter.md
# ascon_permutation_iter

Parametrised, iterative Ascon permutation engine with a start/valid handshake and an internal round counter. It runs any round count from 1 to 12: p^a is 12 rounds, p^b is 6 rounds, and 8 is also supported. Each clock cycle it computes `UNROLL` rounds (constant addition, then S-box layer, then linear diffusion layer). It sits between the ASCON128 mode FSM and the state datapath, and replaces the fixed single-round permutation register.

## Interface
Parameters:
- `UNROLL`, default 1: rounds computed per clock. Legal values are 1, 2, 3, 4; any other value is an elaboration error.

Ports:
- `clock_i` in, 1: clock, rising edge.
- `resetb_i` in, 1: asynchronous, active-low reset.
- `start_i` in, 1: request a permutation. Sampled only while `ready_o`=1.
- `rounds_i` in, 4: number of rounds, sampled with `start_i`.
- `state_i` in, 320 (`type_state`, x0..x4): input state, sampled with `start_i`.
- `ready_o` out, 1: engine idle, or in its final/valid cycle; a start is accepted.
- `valid_o` out, 1: one-cycle pulse; `state_o` holds the result.
- `state_o` out, 320 (`type_state`): state register. Holds the result until the next accepted start.
- `abort_i` in, 1: only present with `ASCON_PERM_ABORT_EN`.

## Operation
- FSM states are IDLE and BUSY. Reset enters IDLE.
- Rounds value:
  - Effective round count is n = `rounds_i` if 1 ≤ `rounds_i` ≤ 12; otherwise n = 12 (0 and 13..15 are clamped).
- Round index:
  - The round index r starts at 12−n, so p^b with 6 rounds uses indices 6..11.
  - The constant for index r is ((0xF−r)<<4)|r, XORed into the low byte of x2.
- Accepting a start (`start_i`=1 and `ready_o`=1 on an edge):
  - The register loads `state_i` after min(UNROLL, n) rounds. There is no load bubble.
  - r advances by UNROLL.
  - If rounds remain, the FSM enters BUSY; otherwise it stays in IDLE.
- In BUSY, each edge:
  - Applies stages r..r+UNROLL−1 to `state_o`.
  - Any stage whose index is ≥12 is bypassed (pass-through), so partial last groups are handled.
  - Advances r by UNROLL.
  - On the edge that completes round 11, returns to IDLE.
- Total edges per operation: C = ceil(n/UNROLL).
- `valid_o` is registered. It is high for exactly the one cycle following the edge that completes round 11.
- `ready_o` = (FSM==IDLE). Because of this, `ready_o` is also high during the `valid_o` cycle, and back-to-back starts lose no cycle.
- `start_i` while BUSY is ignored. No queueing; inputs are not captured.
- Arithmetic: r is 4-bit and saturates at 12. No wrap-around.

## Timing
- Reset values:
  - `state_o` = 320'h0.
  - `valid_o` = 0.
  - `ready_o` = 1.
  - FSM = IDLE, r = 0.
- Latency: start is sampled at edge 0 and `valid_o` is high after edge C−1.
  - UNROLL=1: 12 rounds give `valid_o` in cycle 12; 6 rounds give cycle 6.
  - UNROLL=4: 12 rounds give cycle 3; 6 rounds give cycle 2.
- Throughput: one permutation per C cycles.
- `state_o` changes only on accepting or BUSY edges. It is stable from the `valid_o` cycle until the next accepted start.
- Reset asserted mid-operation:
  - Immediate abort: all registers return to their reset values.
  - No `valid_o`.
- The critical path is UNROLL chained rounds; no other logic sits in series.

## Configuration
- `ASCON_PERM_ABORT_EN` defined:
  - Adds the `abort_i` input.
  - `abort_i`=1 on an edge while BUSY: the FSM goes to IDLE and r returns to 0.
  - No `valid_o` pulse; `state_o` keeps the partial value.
  - Abort has priority over round completion on the same edge.
  - In IDLE, abort is ignored.
  - Asserting `abort_i` and `start_i` together in IDLE: the start is accepted.
- Macro undefined:
  - No `abort_i` port.
  - The operation always runs to completion or reset.

## Test plan
- **Reset:** hold `resetb_i`=0 for 3 cycles, with `start_i`=1 → `state_o`=0, `valid_o`=0, `ready_o`=1; no start is accepted.
- **p^a, UNROLL=1:**
  - Stimulus: `state_i` = {x0=64'h80400C0600000000, key 0, nonce 0}, `rounds_i`=12.
  - Required: `valid_o` in cycle 12 only, `ready_o`=0 in cycles 1..11, `state_o` equal to the golden model.
  - Repeat with UNROLL=4: `valid_o` in cycle 3, same result.
- **Partial last group (p^b, UNROLL=4):** `rounds_i`=6 → C=2; the second edge bypasses stages 2..3; `valid_o` in cycle 2; result equals the golden model for rounds 6..11.
- **Clamp and back-to-back:**
  - `rounds_i`=0 → behaves as 12 rounds.
  - A start asserted in the `valid_o` cycle is accepted.
  - A start while BUSY with a different `state_i` is ignored; the result is unchanged.
- **Reset mid-run:** assert `resetb_i` in cycle 5 of a 12-round run → `state_o`=0 immediately, no `valid_o`; the next start runs normally.
- **Abort (`ASCON_PERM_ABORT_EN`):** `abort_i` in cycle 4 → IDLE next edge, no `valid_o`, `state_o` equals the 4-round partial state; abort in IDLE has no effect.
